ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter: the opposite direction of mouse_controller, which only receives device-to-host packets.
- Sends one command byte to the mouse, e.g. 0xF4 "enable data reporting" at power-up and 0xFF "reset".
- Drives the open-drain PS/2 clock and data lines through pull-low enables, and reports ACK, NAK or timeout.
- Asserts rx_inhibit so the receiver ignores bus activity while a transmission is in progress.

---
 rtl/ps2_host_tx.sv | 239 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - Host-to-device PS/2 command transmitter
// Sends one byte over open-drain clock/data pull-low enables and reports ACK, NAK or timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 15000,
    parameter int SETUP_CYCLES   = 100,
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       rx_inhibit,
    output logic       tx_done,
    output logic       tx_error,
    output logic       err_timeout
);

    localparam int PHASE_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int PW = $clog2(PHASE_MAX + 1);
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PW-1:0] INH_LAST   = PW'(INHIBIT_CYCLES - 1);
    localparam logic [PW-1:0] SETUP_LAST = PW'(SETUP_CYCLES - 1);
    localparam logic [FW-1:0] FILT_LAST  = FW'(FILTER_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
    logic          data_meta_q, data_meta_d, data_sync_q, data_sync_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall_q, fall_d;
    logic [PW-1:0] phase_cnt_q, phase_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [FW-1:0] idle_cnt_q, idle_cnt_d;
    logic          ack_q, ack_d;
    logic          clk_drive_low_q, clk_drive_low_d;
    logic          data_drive_low_q, data_drive_low_d;
    logic          tx_ready_q, tx_ready_d;
    logic          rx_inhibit_q, rx_inhibit_d;
    logic          tx_done_q, tx_done_d;
    logic          tx_error_q, tx_error_d;
    logic          err_timeout_q, err_timeout_d;

    always_comb begin
        clk_meta_d  = ps2_clk_in;
        clk_sync_d  = clk_meta_q;
        data_meta_d = ps2_data_in;
        data_sync_d = data_meta_q;

        // Accept a new clock level only after FILTER_CYCLES consecutive differing samples
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q != filt_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                filt_d = clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
        fall_d = filt_q & ~filt_d;

        state_d          = state_q;
        phase_cnt_d      = phase_cnt_q;
        bit_cnt_d        = bit_cnt_q;
        shift_d          = shift_q;
        to_cnt_d         = to_cnt_q;
        idle_cnt_d       = idle_cnt_q;
        ack_d            = ack_q;
        clk_drive_low_d  = clk_drive_low_q;
        data_drive_low_d = data_drive_low_q;
        tx_done_d        = 1'b0;
        tx_error_d       = 1'b0;
        err_timeout_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    shift_d          = {~^tx_data, tx_data};
                    bit_cnt_d        = '0;
                    phase_cnt_d      = '0;
                    clk_drive_low_d  = 1'b1;
                    data_drive_low_d = 1'b0;
                    state_d          = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (phase_cnt_q == INH_LAST) begin
                    phase_cnt_d      = '0;
                    data_drive_low_d = 1'b1;
                    state_d          = S_START;
                end else begin
                    phase_cnt_d = phase_cnt_q + 1'b1;
                end
            end
            S_START: begin
                if (phase_cnt_q == SETUP_LAST) begin
                    phase_cnt_d     = '0;
                    clk_drive_low_d = 1'b0;
                    to_cnt_d        = '0;
                    state_d         = S_SEND;
                end else begin
                    phase_cnt_d = phase_cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (fall_q) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    // Tenth fall is the stop bit: release data and await the device ACK
                    if (bit_cnt_q == 4'd9) begin
                        data_drive_low_d = 1'b0;
                        state_d          = S_ACK;
                    end else begin
                        data_drive_low_d = ~shift_q[0];
                        shift_d          = {1'b0, shift_q[8:1]};
                    end
                end
            end
            S_ACK: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (fall_q) begin
                    ack_d      = ~data_sync_q;
                    idle_cnt_d = '0;
                    state_d    = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (clk_sync_q && data_sync_q) begin
                    if (idle_cnt_q == FILT_LAST) begin
                        idle_cnt_d = '0;
                        tx_done_d  = ack_q;
                        tx_error_d = ~ack_q;
                        state_d    = S_IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            default: begin
                clk_drive_low_d  = 1'b0;
                data_drive_low_d = 1'b0;
                state_d          = S_IDLE;
            end
        endcase

        // Timeout overrides everything, including an ACK fall in the same cycle
        if ((state_q == S_SEND || state_q == S_ACK || state_q == S_WAIT_IDLE) &&
            to_cnt_q == TO_LAST) begin
            clk_drive_low_d  = 1'b0;
            data_drive_low_d = 1'b0;
            tx_done_d        = 1'b0;
            tx_error_d       = 1'b1;
            err_timeout_d    = 1'b1;
            state_d          = S_IDLE;
        end

        tx_ready_d   = (state_d == S_IDLE);
        rx_inhibit_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            clk_meta_q       <= 1'b1;
            clk_sync_q       <= 1'b1;
            data_meta_q      <= 1'b1;
            data_sync_q      <= 1'b1;
            filt_q           <= 1'b1;
            filt_cnt_q       <= '0;
            fall_q           <= 1'b0;
            phase_cnt_q      <= '0;
            bit_cnt_q        <= '0;
            shift_q          <= '0;
            to_cnt_q         <= '0;
            idle_cnt_q       <= '0;
            ack_q            <= 1'b0;
            clk_drive_low_q  <= 1'b0;
            data_drive_low_q <= 1'b0;
            tx_ready_q       <= 1'b1;
            rx_inhibit_q     <= 1'b0;
            tx_done_q        <= 1'b0;
            tx_error_q       <= 1'b0;
            err_timeout_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            clk_meta_q       <= clk_meta_d;
            clk_sync_q       <= clk_sync_d;
            data_meta_q      <= data_meta_d;
            data_sync_q      <= data_sync_d;
            filt_q           <= filt_d;
            filt_cnt_q       <= filt_cnt_d;
            fall_q           <= fall_d;
            phase_cnt_q      <= phase_cnt_d;
            bit_cnt_q        <= bit_cnt_d;
            shift_q          <= shift_d;
            to_cnt_q         <= to_cnt_d;
            idle_cnt_q       <= idle_cnt_d;
            ack_q            <= ack_d;
            clk_drive_low_q  <= clk_drive_low_d;
            data_drive_low_q <= data_drive_low_d;
            tx_ready_q       <= tx_ready_d;
            rx_inhibit_q     <= rx_inhibit_d;
            tx_done_q        <= tx_done_d;
            tx_error_q       <= tx_error_d;
            err_timeout_q    <= err_timeout_d;
        end
    end

    assign tx_ready           = tx_ready_q;
    assign rx_inhibit         = rx_inhibit_q;
    assign ps2_clk_drive_low  = clk_drive_low_q;
    assign ps2_data_drive_low = data_drive_low_q;
    assign tx_done            = tx_done_q;
    assign tx_error           = tx_error_q;
    assign err_timeout        = err_timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - Self-checking bench for ps2_host_tx with a behavioural PS/2 device
module tb_ps2_host_tx;

    localparam int INH  = 60;
    localparam int SU   = 10;
    localparam int FILT = 4;
    localparam int TO   = 4000;
    localparam int H    = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       glitch_low = 1'b0;
    logic       tx_ready, ps2_clk_in, ps2_data_in;
    logic       ps2_clk_drive_low, ps2_data_drive_low;
    logic       rx_inhibit, tx_done, tx_error, err_timeout;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_drive_low & ~glitch_low;
    assign ps2_data_in = dev_data & ~ps2_data_drive_low;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .SETUP_CYCLES  (SU),
        .FILTER_CYCLES (FILT),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .ps2_clk_in        (ps2_clk_in),
        .ps2_data_in       (ps2_data_in),
        .ps2_clk_drive_low (ps2_clk_drive_low),
        .ps2_data_drive_low(ps2_data_drive_low),
        .rx_inhibit        (rx_inhibit),
        .tx_done           (tx_done),
        .tx_error          (tx_error),
        .err_timeout       (err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_done = 0, n_nak = 0, n_to = 0;
    bit busy_m = 1'b0;
    bit acc_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic [9:0] f;
        for (int i = 0; i < 8; i++) f[i] = b[i];
        f[8] = ($countones(b) % 2 == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
        acc_seen = !reset && tx_valid && !busy_m;
    end

    // Per-cycle model: busy from acceptance until the single completion pulse
    initial forever begin
        @(negedge clk or posedge reset);
        if (reset) begin
            busy_m = 1'b0;
        end else begin
            if (tx_done || tx_error) begin
                check("pulse_only_when_busy", {31'd0, busy_m}, 32'd1);
                busy_m = 1'b0;
                if (tx_done) n_done++;
                else if (err_timeout) n_to++;
                else n_nak++;
            end else if (acc_seen) begin
                busy_m = 1'b1;
            end
            check("tx_ready", {31'd0, tx_ready}, {31'd0, !busy_m});
            check("rx_inhibit", {31'd0, rx_inhibit}, {31'd0, busy_m});
            if (!busy_m) check("idle_bus_released", {30'd0, ps2_clk_drive_low, ps2_data_drive_low}, 32'd0);
            check("done_error_exclusive", {31'd0, tx_done & tx_error}, 32'd0);
            check("err_timeout_qualified", {31'd0, err_timeout & ~tx_error}, 32'd0);
        end
    end

    // mode: 0 ACK, 1 NAK, 2 device silent, 3 reset after 4th fall, 4 ACK with stray tx_valid
    task automatic run_xfer(input logic [7:0] b, input int mode, input bit glitch,
                            output logic [9:0] frame);
        int d0, k0, t0, n, gl, t_rel;
        d0 = n_done; k0 = n_nak; t0 = n_to;
        frame = '0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (ps2_clk_drive_low && !ps2_data_drive_low && n < INH + 50) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_len", n, INH);
        n = 0;
        while (ps2_clk_drive_low && ps2_data_drive_low && n < SU + 50) begin
            n++;
            @(negedge clk);
        end
        check("setup_len", n, SU);
        check("start_bit", {30'd0, ps2_clk_drive_low, ps2_data_drive_low}, 32'd1);
        t_rel = cyc;
        if (mode == 2) begin
            n = 0;
            while (!tx_error && n < TO + 100) begin
                n++;
                @(negedge clk);
            end
            check("timeout_latency", cyc - t_rel, TO);
            check("timeout_flag", {31'd0, err_timeout}, 32'd1);
            check("timeout_bus", {30'd0, ps2_clk_drive_low, ps2_data_drive_low}, 32'd0);
            @(negedge clk);
            check("timeout_count", n_to - t0, 1);
            check("timeout_no_done", n_done - d0, 0);
            return;
        end
        repeat (H) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            if (mode == 3 && k == 4) begin
                #3 reset = 1'b1;
                #1;
                check("rst_bus", {30'd0, ps2_clk_drive_low, ps2_data_drive_low}, 32'd0);
                check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
                check("rst_rx_inhibit", {31'd0, rx_inhibit}, 32'd0);
                repeat (3) @(negedge clk);
                dev_clk  = 1'b1;
                dev_data = 1'b1;
                reset    = 1'b0;
                repeat (5) @(negedge clk);
                return;
            end
            if (k <= 10) frame[k-1] = ps2_data_in;
            else check("ack_data_released", {31'd0, ps2_data_drive_low}, 32'd0);
            if (mode == 4 && k == 3) begin
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
            dev_clk = 1'b1;
            if (k == 10) dev_data = (mode == 1);
            if (k == 11) dev_data = 1'b1;
            gl = $urandom_range(1, 3);
            for (int c = 0; c < H; c++) begin
                if (glitch && k <= 10 && c == 10) glitch_low = 1'b1;
                if (c == 10 + gl) glitch_low = 1'b0;
                @(negedge clk);
            end
        end
        n = 0;
        while (n_done == d0 && n_nak == k0 && n_to == t0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        check("done_count", n_done - d0, (mode == 1) ? 0 : 1);
        check("nak_count", n_nak - k0, (mode == 1) ? 1 : 0);
        check("no_timeout", n_to - t0, 0);
        check("frame", {22'd0, frame}, {22'd0, frame_of(b)});
        check("ready_after", {31'd0, tx_ready}, 32'd1);
    endtask

    initial begin
        logic [9:0] fr;
        logic [7:0] rb;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, tx_ready}, 32'd1);
        check("reset_inhibit", {31'd0, rx_inhibit}, 32'd0);
        check("reset_bus", {30'd0, ps2_clk_drive_low, ps2_data_drive_low}, 32'd0);
        check("reset_pulses", {29'd0, tx_done, tx_error, err_timeout}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        run_xfer(8'hF4, 0, 1'b0, fr);
        check("frame_f4_literal", {22'd0, fr}, 32'h2F4);
        run_xfer(8'h00, 0, 1'b0, fr);
        check("frame_00_literal", {22'd0, fr}, 32'h300);
        run_xfer(8'hFF, 0, 1'b0, fr);
        check("frame_ff_literal", {22'd0, fr}, 32'h3FF);
        run_xfer(8'hA5, 1, 1'b0, fr);
        run_xfer(8'h3C, 2, 1'b0, fr);
        repeat (10) @(negedge clk);
        run_xfer(8'hF4, 3, 1'b0, fr);
        run_xfer(8'hFF, 0, 1'b0, fr);
        check("frame_ff_after_reset", {22'd0, fr}, 32'h3FF);
        run_xfer(8'hF4, 4, 1'b1, fr);
        check("frame_f4_stray_valid", {22'd0, fr}, 32'h2F4);
        repeat (20) @(negedge clk);
        check("no_queued_request", {31'd0, ps2_clk_drive_low}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom);
            run_xfer(rb, ($urandom_range(0, 3) == 0) ? 1 : 0, 1'($urandom_range(0, 1)), fr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
